// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and holds the
// returned word for decode until the core retires it. Misaligned next PCs halt fetch.
module fetch_unit #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            retire,
    input  logic            PCSrc,
    input  logic            Jalr,
    input  logic [XLEN-1:0] PCTarget,
    input  logic [XLEN-1:0] ALUResult,
    output logic            fetch_fault
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] FAULT = 2'd3;

    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] jalr_target;

    assign pc_plus4    = pc_q + XLEN'(4);
    assign jalr_target = ALUResult & ~XLEN'(1);

    // Jalr outranks PCSrc: a jalr also asserts PCSrc in the controller.
    assign next_pc = Jalr  ? jalr_target :
                     PCSrc ? PCTarget    :
                             pc_plus4;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (retire) begin
                    // The misaligned target is still loaded so a debugger can see it.
                    pc_d    = next_pc;
                    state_d = (next_pc[1:0] != 2'b00) ? FAULT : FETCH;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == HOLD);
    assign pc          = pc_q;
    assign fetch_fault = (state_q == FAULT);

endmodule
